// File: rtl/bus_resp_pkg.sv
// Shared definitions for the CU command-bus responder: bus geometry, opcode
// map, FSM state encoding and the single-cycle execution helper.
package bus_resp_pkg;

    localparam int DATA_W    = 16;
    localparam int OP_W      = 4;
    localparam int IMM_W     = 12;
    localparam int MUL_STEPS = 8;
    localparam int MUL_OPW   = 8;

    // Command word field positions
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int IMM_HI = 11;
    localparam int IMM_LO = 0;

    // Opcode map; 0xB..0xE are illegal (0xA too when MUL is not built)
    localparam logic [OP_W-1:0] OP_NOP = 4'h0;
    localparam logic [OP_W-1:0] OP_LDI = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB = 4'h3;
    localparam logic [OP_W-1:0] OP_AND = 4'h4;
    localparam logic [OP_W-1:0] OP_OR  = 4'h5;
    localparam logic [OP_W-1:0] OP_XOR = 4'h6;
    localparam logic [OP_W-1:0] OP_SHL = 4'h7;
    localparam logic [OP_W-1:0] OP_SHR = 4'h8;
    localparam logic [OP_W-1:0] OP_LDH = 4'h9;
    localparam logic [OP_W-1:0] OP_MUL = 4'hA;
    localparam logic [OP_W-1:0] OP_CLR = 4'hF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] acc;
        logic              carry;
        logic              err;
    } alu_res_t;

    // Result of every single-cycle opcode. MUL is not handled here: the top
    // diverts it to the multiplier when that is built, otherwise it falls
    // into the illegal branch like 0xB..0xE.
    function automatic alu_res_t exec_op(
        input logic [OP_W-1:0]   op,
        input logic [DATA_W-1:0] acc,
        input logic              carry,
        input logic              err,
        input logic [DATA_W-1:0] imm
    );
        alu_res_t    res;
        logic [16:0] wide;
        res.acc   = acc;
        res.carry = carry;
        res.err   = err;
        wide      = 17'h0_0000;
        case (op)
            OP_NOP: begin
                res.acc = acc;
            end
            OP_LDI: begin
                res.acc = imm;
            end
            OP_ADD: begin
                wide      = {1'b0, acc} + {1'b0, imm};
                res.acc   = wide[15:0];
                res.carry = wide[16];
            end
            OP_SUB: begin
                // bit 16 of the 17-bit difference is the borrow
                wide      = {1'b0, acc} - {1'b0, imm};
                res.acc   = wide[15:0];
                res.carry = wide[16];
            end
            OP_AND: begin
                res.acc = acc & imm;
            end
            OP_OR: begin
                res.acc = acc | imm;
            end
            OP_XOR: begin
                res.acc = acc ^ imm;
            end
            OP_SHL: begin
                // the guard bit above the MSB catches the last bit shifted out
                wide      = {1'b0, acc} << imm[3:0];
                res.acc   = wide[15:0];
                res.carry = wide[16];
            end
            OP_SHR: begin
                // the guard bit below the LSB catches the last bit shifted out
                wide      = {acc, 1'b0} >> imm[3:0];
                res.acc   = wide[16:1];
                res.carry = wide[0];
            end
            OP_LDH: begin
                res.acc = {imm[3:0], acc[11:0]};
            end
            OP_CLR: begin
                res.acc   = 16'h0000;
                res.carry = 1'b0;
                res.err   = 1'b0;
            end
            default: begin
                res.err = 1'b1;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bus_resp_mul.sv
// 8x8 shift-add multiplier for the responder's MUL opcode.
// start loads the operands; one partial product is added per un-stalled
// cycle. done is asserted combinationally on the final step together with
// the complete product, so the caller can capture it on that same edge.
module bus_resp_mul
    import bus_resp_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stall,
    input  logic [MUL_OPW-1:0] op_a,
    input  logic [MUL_OPW-1:0] op_b,
    output logic               done,
    output logic [DATA_W-1:0]  product
);

    localparam int CNT_W = $clog2(MUL_STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

    logic               busy_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [MUL_OPW-1:0] a_r;
    logic [MUL_OPW-1:0] b_r;
    logic [DATA_W-1:0]  prod_r;
    logic [DATA_W-1:0]  partial_s;
    logic [DATA_W-1:0]  sum_s;
    logic               step_s;

    // Partial product for the current multiplier bit and the running sum
    always_comb begin
        partial_s = 16'h0000;
        if (b_r[cnt_r]) begin
            partial_s = {8'h00, a_r} << cnt_r;
        end else begin
            partial_s = 16'h0000;
        end
        sum_s  = prod_r + partial_s;
        step_s = busy_r & ~stall;
    end

    assign done    = step_s & (cnt_r == LAST_STEP);
    assign product = sum_s;

    // Operand capture on start, then one accumulate step per enabled cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= 1'b0;
            cnt_r  <= '0;
            a_r    <= 8'h00;
            b_r    <= 8'h00;
            prod_r <= 16'h0000;
        end else if (start) begin
            busy_r <= 1'b1;
            cnt_r  <= '0;
            a_r    <= op_a;
            b_r    <= op_b;
            prod_r <= 16'h0000;
        end else if (step_s) begin
            prod_r <= sum_s;
            cnt_r  <= cnt_r + CNT_W'(1);
            if (cnt_r == LAST_STEP) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= 1'b1;
            end
        end else begin
            busy_r <= busy_r;
        end
    end

endmodule

// File: rtl/bus_acc_responder.sv
// Responder end of the CU command bus: executes 16-bit commands against a
// 16-bit accumulator and returns it with zero/carry/error flags.
// Build option: BUS_RESP_MUL_EN adds the multi-cycle MUL opcode (0xA) and the
// MUL state; without it 0xA is illegal and ac_ready stays 1 out of reset.
module bus_acc_responder
    import bus_resp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              cu_valid,
    input  logic [DATA_W-1:0] cu_data,
    output logic              ac_ready,
    output logic              ac_valid,
    output logic [DATA_W-1:0] ac_data,
    output logic              ac_zero,
    output logic              ac_carry,
    output logic              ac_err
);

    state_t            state_r;
    state_t            state_s;
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] acc_s;
    logic              carry_r;
    logic              carry_s;
    logic              err_r;
    logic              err_s;
    logic              zero_r;
    logic              zero_s;
    logic              valid_r;
    logic              valid_s;
    logic              ready_r;

    logic              accept_s;
    logic [OP_W-1:0]   op_s;
    logic [DATA_W-1:0] imm_s;
    alu_res_t          alu_s;

    assign op_s     = cu_data[OP_HI:OP_LO];
    assign imm_s    = {4'h0, cu_data[IMM_HI:IMM_LO]};
    assign accept_s = en & cu_valid & ready_r;
    assign alu_s    = exec_op(op_s, acc_r, carry_r, err_r, imm_s);

`ifdef BUS_RESP_MUL_EN
    logic              mul_start_s;
    logic              mul_done_s;
    logic [DATA_W-1:0] mul_prod_s;

    bus_resp_mul u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start_s),
        .stall   (~en),
        .op_a    (acc_r[7:0]),
        .op_b    (cu_data[7:0]),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );
`endif

    // Next state, accumulator and flag update for the command being accepted or finished
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        carry_s = carry_r;
        err_s   = err_r;
        valid_s = 1'b0;
`ifdef BUS_RESP_MUL_EN
        mul_start_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
`ifdef BUS_RESP_MUL_EN
                    if (op_s == OP_MUL) begin
                        mul_start_s = 1'b1;
                        state_s     = ST_MUL;
                    end else begin
                        acc_s   = alu_s.acc;
                        carry_s = alu_s.carry;
                        err_s   = alu_s.err;
                        valid_s = 1'b1;
                    end
`else
                    acc_s   = alu_s.acc;
                    carry_s = alu_s.carry;
                    err_s   = alu_s.err;
                    valid_s = 1'b1;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
`ifdef BUS_RESP_MUL_EN
                // the multiplier holds while en is low, so done waits for it
                if (mul_done_s) begin
                    acc_s   = mul_prod_s;
                    valid_s = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_MUL;
                end
`else
                state_s = ST_IDLE;
`endif
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // zero tracks the accumulator only when a command completes
        if (valid_s) begin
            zero_s = (acc_s == 16'h0000);
        end else begin
            zero_s = zero_r;
        end
    end

    // State, accumulator and output registers; reset aborts any multiply in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            acc_r   <= 16'h0000;
            carry_r <= 1'b0;
            err_r   <= 1'b0;
            zero_r  <= 1'b1;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            carry_r <= carry_s;
            err_r   <= err_s;
            zero_r  <= zero_s;
            valid_r <= valid_s;
            ready_r <= (state_s == ST_IDLE);
        end
    end

    assign ac_ready = ready_r;
    assign ac_valid = valid_r;
    assign ac_data  = acc_r;
    assign ac_zero  = zero_r;
    assign ac_carry = carry_r;
    assign ac_err   = err_r;

endmodule

// File: tb/tb_bus_acc_responder.sv
// Scoreboard bench for bus_acc_responder: the stimulus process pushes the
// hand-computed response of each accepted command, a monitor pops and compares
// on every ac_valid. MUL scenarios follow BUS_RESP_MUL_EN.
module tb_bus_acc_responder;

    typedef struct packed {
        logic [15:0] data;
        logic        zero;
        logic        carry;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        reset;
    logic        en;
    logic        cu_valid;
    logic [15:0] cu_data;
    logic        ac_ready;
    logic        ac_valid;
    logic [15:0] ac_data;
    logic        ac_zero;
    logic        ac_carry;
    logic        ac_err;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   tests;
    int   fails;
    int   low_cnt;

    bus_acc_responder dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .cu_valid (cu_valid),
        .cu_data  (cu_data),
        .ac_ready (ac_ready),
        .ac_valid (ac_valid),
        .ac_data  (ac_data),
        .ac_zero  (ac_zero),
        .ac_carry (ac_carry),
        .ac_err   (ac_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_rsp(input logic [15:0] data, input logic zero, input logic carry, input logic err);
        rsp_t r;
        r.data  = data;
        r.zero  = zero;
        r.carry = carry;
        r.err   = err;
        exp_q.push_back(r);
    endtask

    // present a command for one clock edge, leaving cu_valid asserted
    task automatic cmd(input logic [3:0] op, input logic [11:0] imm);
        cu_valid = 1'b1;
        cu_data  = {op, imm};
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        cu_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // count negedges with ac_ready low after an accept; en dropped while count is in [drop_lo, drop_hi]
    task automatic count_busy(input int drop_lo, input int drop_hi, output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ac_ready) break;
            cnt++;
            en = !(cnt >= drop_lo && cnt <= drop_hi);
            if (cnt == 2) begin
                cu_valid = 1'b1;
                cu_data  = 16'h1111;
            end
            if (cnt == 4) cu_valid = 1'b0;
        end
        en = 1'b1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset && ac_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got ac_data=0x%04h with no response pending at %0t", ac_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_data",  {16'h0, ac_data},  {16'h0, mon_e.data});
                check("rsp_zero",  {31'h0, ac_zero},  {31'h0, mon_e.zero});
                check("rsp_carry", {31'h0, ac_carry}, {31'h0, mon_e.carry});
                check("rsp_err",   {31'h0, ac_err},   {31'h0, mon_e.err});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests    = 0;
        fails    = 0;
        reset    = 1'b0;
        en       = 1'b1;
        cu_valid = 1'b0;
        cu_data  = 16'h0000;
        #50;
        check("rst_data",  {16'h0, ac_data},  32'h0);
        check("rst_valid", {31'h0, ac_valid}, 32'h0);
        check("rst_zero",  {31'h0, ac_zero},  32'h1);
        check("rst_carry", {31'h0, ac_carry}, 32'h0);
        check("rst_err",   {31'h0, ac_err},   32'h0);
        check("rst_ready", {31'h0, ac_ready}, 32'h1);
        #35;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // single load
        expect_rsp(16'h0123, 1'b0, 1'b0, 1'b0);
        cmd(4'h1, 12'h123);
        idle(2);

        // back-to-back LDI / LDH / ADD wrap
        expect_rsp(16'h0FFF, 1'b0, 1'b0, 1'b0);
        expect_rsp(16'hFFFF, 1'b0, 1'b0, 1'b0);
        expect_rsp(16'h0000, 1'b1, 1'b1, 1'b0);
        cmd(4'h1, 12'hFFF);
        cmd(4'h9, 12'h00F);
        cmd(4'h2, 12'h001);
        idle(2);

        // SUB borrow, logic ops keep carry, shifts incl. shift by 0
        expect_rsp(16'hFFFF, 1'b0, 1'b1, 1'b0);  cmd(4'h3, 12'h001);
        expect_rsp(16'h00F0, 1'b0, 1'b1, 1'b0);  cmd(4'h4, 12'h0F0);
        expect_rsp(16'h00FF, 1'b0, 1'b1, 1'b0);  cmd(4'h5, 12'h00F);
        expect_rsp(16'h0000, 1'b1, 1'b1, 1'b0);  cmd(4'h6, 12'h0FF);
        expect_rsp(16'h0801, 1'b0, 1'b1, 1'b0);  cmd(4'h1, 12'h801);
        expect_rsp(16'h0020, 1'b0, 1'b1, 1'b0);  cmd(4'h7, 12'h005);
        expect_rsp(16'h0010, 1'b0, 1'b0, 1'b0);  cmd(4'h8, 12'h001);
        expect_rsp(16'h0000, 1'b1, 1'b1, 1'b0);  cmd(4'h8, 12'h005);
        expect_rsp(16'h0003, 1'b0, 1'b1, 1'b0);  cmd(4'h1, 12'h003);
        expect_rsp(16'h0003, 1'b0, 1'b0, 1'b0);  cmd(4'h7, 12'h000);
        expect_rsp(16'h0003, 1'b0, 1'b0, 1'b0);  cmd(4'h0, 12'hABC);
        idle(2);

        // illegal opcode: sticky error until CLR
        expect_rsp(16'h0003, 1'b0, 1'b0, 1'b1);  cmd(4'hC, 12'h000);
        expect_rsp(16'h0055, 1'b0, 1'b0, 1'b1);  cmd(4'h1, 12'h055);
        expect_rsp(16'h0000, 1'b1, 1'b0, 1'b0);  cmd(4'hF, 12'h000);
        idle(2);

        // en low: command is not accepted
        en = 1'b0;
        cmd(4'h1, 12'h777);
        en = 1'b1;
        idle(2);
        check("en_gate_data", {16'h0, ac_data}, 32'h0);

`ifdef BUS_RESP_MUL_EN
        // MUL, with a second command presented while busy
        expect_rsp(16'h00FF, 1'b0, 1'b0, 1'b0);
        cmd(4'h1, 12'h0FF);
        cmd(4'hA, 12'h0FF);
        cu_valid = 1'b0;
        expect_rsp(16'hFE01, 1'b0, 1'b0, 1'b0);
        count_busy(100, 100, low_cnt);
        check("mul_busy_cycles", low_cnt, 32'd8);
        idle(3);

        // MUL with en dropped for three cycles
        expect_rsp(16'h00FF, 1'b0, 1'b0, 1'b0);
        cmd(4'h1, 12'h0FF);
        cmd(4'hA, 12'h0FF);
        cu_valid = 1'b0;
        expect_rsp(16'hFE01, 1'b0, 1'b0, 1'b0);
        count_busy(3, 5, low_cnt);
        check("mul_stall_cycles", low_cnt, 32'd11);
        idle(3);

        // reset in the middle of a multiply
        expect_rsp(16'h00FF, 1'b0, 1'b0, 1'b0);
        cmd(4'h1, 12'h0FF);
        cmd(4'hA, 12'h0FF);
        idle(3);
        check("mul_mid_ready", {31'h0, ac_ready}, 32'h0);
        reset = 1'b0;
        #1;
        check("mul_rst_data",  {16'h0, ac_data},  32'h0);
        check("mul_rst_ready", {31'h0, ac_ready}, 32'h1);
        check("mul_rst_zero",  {31'h0, ac_zero},  32'h1);
        @(negedge clk);
        reset = 1'b1;
        idle(12);
        check("mul_abort_data", {16'h0, ac_data}, 32'h0);
`else
        // 0xA without the multiplier: illegal, single-cycle, ready never drops
        expect_rsp(16'h0000, 1'b1, 1'b0, 1'b1);
        cmd(4'hA, 12'h0FF);
        cu_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("nomul_ready", {31'h0, ac_ready}, 32'h1);
        end
        @(posedge clk);
        #1;
        expect_rsp(16'h0000, 1'b1, 1'b0, 1'b0);
        cmd(4'hF, 12'h000);
`endif
        idle(4);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
